// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD segment scanner: scan FSM states,
// BS segment numbering and the packed segment-address layout.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EMIT,
    EMIT_BS,
    DONE
  } scan_state_t;

  localparam logic [7:0] SEG_BS_BASE = 8'd128;
  localparam int         LCD_H_COUNT = 4;

  // RAM-sourced segments occupy 0..127 as {plane, O[3:0], H[1:0]}.
  function automatic logic [7:0] seg_ram_addr(input logic       plane,
                                              input logic [3:0] o,
                                              input logic [1:0] h);
    return {1'b0, plane, o, h};
  endfunction

endpackage

// File: rtl/lcd_segment_scanner.sv
// Frame scanner for the SM510 display RAM: reads each display word, expands it
// into four per-common segment beats, then appends the BS segments from L/Y.
module lcd_segment_scanner
  import lcd_pkg::*;
#(
  parameter logic [6:0] RAM_BASE    = 7'h60,
  parameter int         WORDS       = 32,
  parameter int         RAM_LATENCY = 1,
  parameter int         BS_ENABLE   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       lcd_bp,
  input  logic       lcd_bc,
  input  logic [3:0] segment_l,
  input  logic [3:0] segment_y,
  input  logic       ram_busy,
  output logic       ram_rd_en,
  output logic [6:0] ram_rd_addr,
  input  logic [3:0] ram_rd_data,
  output logic       seg_valid,
  input  logic       seg_ready,
  output logic [7:0] seg_addr,
  output logic       seg_on,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [4:0] LAST_W   = 5'(WORDS - 1);
  localparam logic [1:0] LAST_LAT = 2'(RAM_LATENCY - 1);
  localparam logic [1:0] LAST_H   = 2'(LCD_H_COUNT - 1);

  if (int'(RAM_BASE) + WORDS > 128) begin : g_bad_range
    $error("lcd_segment_scanner: RAM_BASE + WORDS exceeds 128");
  end
  if (WORDS < 1 || WORDS > 32) begin : g_bad_words
    $error("lcd_segment_scanner: WORDS must be 1..32");
  end
  if (RAM_LATENCY < 1 || RAM_LATENCY > 2) begin : g_bad_latency
    $error("lcd_segment_scanner: RAM_LATENCY must be 1 or 2");
  end

  scan_state_t state_q, state_d;
  logic [4:0]  w_q, w_d;
  logic [1:0]  h_q, h_d;
  logic [1:0]  lat_q, lat_d;
  logic [3:0]  data_q, data_d;
  logic        blank_q, blank_d;
  logic [3:0]  l_q, l_d;
  logic [3:0]  y_q, y_d;
  logic        pending_q, pending_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      lat_q     <= '0;
      data_q    <= '0;
      blank_q   <= 1'b0;
      l_q       <= '0;
      y_q       <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      lat_q     <= lat_d;
      data_q    <= data_d;
      blank_q   <= blank_d;
      l_q       <= l_d;
      y_q       <= y_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    lat_d       = lat_q;
    data_d      = data_q;
    blank_d     = blank_q;
    l_d         = l_q;
    y_d         = y_q;
    // A tick outside IDLE is remembered once; extra ticks collapse into it.
    pending_d   = pending_q | (frame_tick & (state_q != IDLE));
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    seg_valid   = 1'b0;
    seg_addr    = '0;
    seg_on      = 1'b0;
    busy        = (state_q != IDLE);
    frame_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          blank_d = lcd_bc | ~lcd_bp;
          l_d     = segment_l;
          y_d     = segment_y;
          w_d     = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        ram_rd_addr = RAM_BASE + 7'(w_q);
        if (!ram_busy) begin
          ram_rd_en = 1'b1;
          lat_d     = '0;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        if (lat_q == LAST_LAT) begin
          data_d  = ram_rd_data;
          h_d     = '0;
          state_d = EMIT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      EMIT: begin
        seg_valid = 1'b1;
        seg_addr  = seg_ram_addr(w_q[4], w_q[3:0], h_q);
        seg_on    = data_q[h_q] & ~blank_q;
        if (seg_ready) begin
          if (h_q == LAST_H) begin
            h_d = '0;
            if (w_q == LAST_W) begin
              state_d = (BS_ENABLE != 0) ? EMIT_BS : DONE;
            end else begin
              w_d     = w_q + 5'd1;
              state_d = REQ;
            end
          end else begin
            h_d = h_q + 2'd1;
          end
        end
      end

      EMIT_BS: begin
        seg_valid = 1'b1;
        seg_addr  = SEG_BS_BASE + 8'(h_q);
        seg_on    = l_q[h_q] & y_q[h_q] & ~blank_q;
        if (seg_ready) begin
          if (h_q == LAST_H) begin
            h_d     = '0;
            state_d = DONE;
          end else begin
            h_d = h_q + 2'd1;
          end
        end
      end

      DONE: begin
        frame_done = 1'b1;
        // Back-to-back frame: latch the new snapshot here, skipping IDLE.
        if (pending_q | frame_tick) begin
          blank_d   = lcd_bc | ~lcd_bp;
          l_d       = segment_l;
          y_d       = segment_y;
          w_d       = '0;
          pending_d = 1'b0;
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_segment_scanner.sv
// Randomized self-checking bench for lcd_segment_scanner: a behavioural RAM,
// a per-frame expected beat list, and a monitor on the segment stream.
module tb_lcd_segment_scanner;

  localparam int BEATS = 132;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       lcd_bp = 1'b1;
  logic       lcd_bc = 1'b0;
  logic [3:0] segment_l = '0;
  logic [3:0] segment_y = '0;
  logic       ram_busy = 1'b0;
  logic       ram_rd_en;
  logic [6:0] ram_rd_addr;
  logic [3:0] ram_rd_data = '0;
  logic       seg_valid;
  logic       seg_ready = 1'b1;
  logic [7:0] seg_addr;
  logic       seg_on;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  lcd_segment_scanner dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .lcd_bp     (lcd_bp),
    .lcd_bc     (lcd_bc),
    .segment_l  (segment_l),
    .segment_y  (segment_y),
    .ram_busy   (ram_busy),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .seg_addr   (seg_addr),
    .seg_on     (seg_on),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Behavioural display RAM with one cycle of read latency.
  logic [3:0] mem [0:127];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected beat stream for one frame, derived from the display rules.
  int exp_addr[$];
  bit exp_on[$];

  task automatic push_frame(input bit blank, input logic [3:0] l, input logic [3:0] y);
    for (int a = 0; a < 128; a++) begin
      logic [3:0] word;
      word = mem[8'h60 + a / 4];
      exp_addr.push_back(a);
      exp_on.push_back(word[a % 4] & !blank);
    end
    for (int h = 0; h < 4; h++) begin
      exp_addr.push_back(128 + h);
      exp_on.push_back(l[h] & y[h] & !blank);
    end
  endtask

  task automatic fill_mem(input bit rnd, input logic [3:0] val);
    for (int i = 0; i < 128; i++) mem[i] = rnd ? 4'($urandom) : val;
  endtask

  // Handshake/arbitration drivers, applied just after each rising edge.
  bit rand_ready = 1'b0;
  bit rand_busy  = 1'b0;
  bit force_busy = 1'b0;
  always @(posedge clk) begin
    #1;
    seg_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    ram_busy  = force_busy | (rand_busy && ($urandom_range(0, 3) == 0));
  end

  // Stream monitor.
  int         beats = 0;
  int         done_cnt = 0;
  bit         expect_b2b = 1'b0;
  bit         chk_next_busy = 1'b0;
  logic       pv = 1'b0, pr = 1'b0, po = 1'b0;
  logic [7:0] pa = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      pv = 1'b0;
      beats = 0;
      chk_next_busy = 1'b0;
    end else begin
      if (ram_busy) check("rd_en_while_ram_busy", 32'(ram_rd_en), 32'd0);
      if (chk_next_busy) begin
        check("no_idle_between_frames", 32'(busy), 32'd1);
        chk_next_busy = 1'b0;
      end
      if (pv && !pr) begin
        check("stall_valid_held", 32'(seg_valid), 32'd1);
        if (seg_valid) begin
          check("stall_addr_stable", 32'(seg_addr), 32'(pa));
          check("stall_on_stable", 32'(seg_on), 32'(po));
        end
      end
      if (seg_valid && seg_ready) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_beat", 32'(seg_addr), 32'hFFFF);
        end else begin
          int ea;
          bit eo;
          ea = exp_addr.pop_front();
          eo = exp_on.pop_front();
          check("beat_addr", 32'(seg_addr), 32'(ea));
          check("beat_on", 32'(seg_on), 32'(eo));
        end
        beats++;
      end
      if (frame_done) begin
        check("beats_per_frame", 32'(beats), 32'(BEATS));
        $display("frame %0d done after %0d beats", done_cnt, beats);
        beats = 0;
        done_cnt++;
        if (expect_b2b) begin
          chk_next_busy = 1'b1;
          expect_b2b = 1'b0;
        end
      end
      pv = seg_valid;
      pr = seg_ready;
      pa = seg_addr;
      po = seg_on;
    end
  end

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("frame_done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {ram_rd_en, ram_rd_addr, seg_valid, seg_addr, seg_on, busy, frame_done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    fill_mem(1'b0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_outputs");
    @(posedge clk); #1 reset_n = 1'b1;

    // Single lit word, exact latency from the tick.
    mem[8'h60] = 4'b1010;
    segment_l = 4'h5; segment_y = 4'h3;
    push_frame(1'b0, segment_l, segment_y);
    tick();
    @(negedge clk);
    check("first_rd_en_cycle1", 32'(ram_rd_en), 32'd1);
    check("first_rd_addr", 32'(ram_rd_addr), 32'h60);
    @(negedge clk);
    check("no_valid_cycle2", 32'(seg_valid), 32'd0);
    @(negedge clk);
    check("first_valid_cycle3", 32'(seg_valid), 32'd1);
    wait_done(1, 2000);
    check("queue_empty_f1", 32'(exp_addr.size()), 32'd0);

    // Blanked frame; BC change mid-frame must not leak in.
    fill_mem(1'b0, 4'hF);
    segment_l = 4'hF; segment_y = 4'hF;
    lcd_bc = 1'b1;
    push_frame(1'b1, segment_l, segment_y);
    tick();
    repeat (10) @(negedge clk);
    lcd_bc = 1'b0;
    wait_done(2, 2000);
    push_frame(1'b0, segment_l, segment_y);
    tick();
    wait_done(3, 2000);

    // CPU holds the RAM port for 5 cycles when word 3 is requested.
    fill_mem(1'b1, 4'h0);
    push_frame(1'b0, segment_l, segment_y);
    tick();
    begin
      int n = 0;
      while (!(seg_valid && seg_addr == 8'd11) && n < 200) begin
        @(negedge clk); n++;
      end
      check("reach_word2_last_beat", 32'(seg_addr), 32'd11);
    end
    force_busy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("held_off_rd_en", 32'(ram_rd_en), 32'd0);
    end
    force_busy = 1'b0;
    @(negedge clk);
    check("rd_after_release", 32'(ram_rd_en), 32'd1);
    check("rd_addr_word3", 32'(ram_rd_addr), 32'h63);
    wait_done(4, 2000);

    // Random backpressure and RAM contention.
    fill_mem(1'b1, 4'h0);
    segment_l = 4'($urandom); segment_y = 4'($urandom);
    rand_ready = 1'b1; rand_busy = 1'b1;
    push_frame(1'b0, segment_l, segment_y);
    tick();
    wait_done(5, 5000);
    rand_ready = 1'b0; rand_busy = 1'b0;
    check("queue_empty_rand", 32'(exp_addr.size()), 32'd0);

    // Three ticks during one scan yield exactly one extra back-to-back frame.
    fill_mem(1'b1, 4'h0);
    segment_l = 4'($urandom); segment_y = 4'($urandom);
    base = done_cnt;
    push_frame(1'b0, segment_l, segment_y);
    push_frame(1'b0, segment_l, segment_y);
    expect_b2b = 1'b1;
    tick();
    repeat (20) @(negedge clk);
    tick();
    repeat (20) @(negedge clk);
    tick();
    repeat (20) @(negedge clk);
    tick();
    wait_done(base + 2, 4000);
    repeat (20) @(negedge clk);
    check("extra_frames", 32'(done_cnt), 32'(base + 2));
    check("idle_after_pending", 32'(busy), 32'd0);

    // Reset in the middle of a frame, then a clean frame.
    fill_mem(1'b1, 4'h0);
    push_frame(1'b0, segment_l, segment_y);
    tick();
    begin
      int n = 0;
      while (beats < 40 && n < 1000) begin
        @(negedge clk); #1; n++;
      end
      check("reach_beat40", 32'(beats >= 40), 32'd1);
    end
    reset_n = 1'b0;
    base = done_cnt;
    @(negedge clk);
    check_idle_outputs("midframe_reset_outputs");
    exp_addr.delete();
    exp_on.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt), 32'(base));
    push_frame(1'b0, segment_l, segment_y);
    tick();
    wait_done(base + 1, 2000);
    check("queue_empty_final", 32'(exp_addr.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_segment_scanner.md
Name: lcd_segment_scanner

Overview:
Display-side reader of the SM510-family segment RAM. The CPU core writes this RAM through its instruction set; the scanner reads it back. On each frame tick it walks the display RAM words (0x60–0x7F), expands each 4-bit word into per-common (H0–H3) segment states, and appends the 4 BS segments from the L/Y latches. Results stream over a valid/ready port to the video segment framebuffer. RAM reads yield to the CPU's RAM access.

Parameters:
RAM_BASE, 7'h60, first display RAM address scanned
WORDS, 32, number of RAM words scanned per frame (plane a = first 16, plane b = next 16)
RAM_LATENCY, 1, cycles from ram_rd_en to valid ram_rd_data (1 or 2)
BS_ENABLE, 1, emit the 4 BS segments after the RAM words

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
frame_tick  in  1  single-cycle pulse requesting a full scan
lcd_bp  in  1  LCD pulse-generator enable (0 = blank)
lcd_bc  in  1  LCD bleeder (1 = blank)
segment_l  in  4  L latch, BS source
segment_y  in  4  Y latch, BS per-H gate
ram_busy  in  1  CPU is using the RAM port this cycle; scanner must not issue a read
ram_rd_en  out  1  read strobe
ram_rd_addr  out  7  read address
ram_rd_data  in  4  read data, valid RAM_LATENCY cycles after an accepted ram_rd_en
seg_valid  out  1  segment beat valid
seg_ready  in  1  downstream accepts beat
seg_addr  out  8  {plane, O[3:0], H[1:0]} for RAM segments (0–127); 128+H for BS
seg_on  out  1  segment state
busy  out  1  scan in progress
frame_done  out  1  single-cycle pulse after the last beat is accepted

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pending, word index and H counter cleared. Reset mid-scan aborts with no frame_done.
- FSM states: IDLE, REQ, WAIT, EMIT, EMIT_BS, DONE.
- IDLE: on frame_tick, latch blank = lcd_bc | ~lcd_bp, latch segment_l and segment_y, set word index w = 0, go to REQ.
- Blank, L and Y stay frozen for the whole frame.
- REQ: drive ram_rd_addr = RAM_BASE + w every cycle. Assert ram_rd_en only when ram_busy = 0. A read is accepted in the cycle ram_rd_en = 1. Then go to WAIT.
- WAIT: count RAM_LATENCY cycles, capture ram_rd_data into a 4-bit holding register, go to EMIT with h = 0.
- EMIT: seg_valid = 1; seg_addr = {w[4], w[3:0], h}; seg_on = data[h] & ~blank.
  - Advance h only when seg_valid & seg_ready.
  - Hold seg_addr and seg_on stable while stalled.
  - After the h = 3 beat is accepted: if w = WORDS-1, go to EMIT_BS (BS_ENABLE = 1) or DONE (BS_ENABLE = 0); otherwise w+1 and go to REQ.
- EMIT_BS: 4 beats, seg_addr = 128 + h, seg_on = segment_l[h] & segment_y[h] & ~blank. Same handshake as EMIT. Go to DONE after h = 3 is accepted.
- DONE: frame_done = 1 for one cycle. Go to REQ (new frame latched) if pending, else IDLE.
- busy = 1 in every state except IDLE.
- frame_tick while busy sets pending (one deep; further ticks are dropped). Pending is cleared when the new frame starts. frame_tick in the DONE cycle also sets pending.
- Latency with ram_busy = 0, RAM_LATENCY = 1, seg_ready = 1:
  - frame_tick at cycle 0 gives ram_rd_en at cycle 1 and the first seg_valid at cycle 3.
  - Each word takes 6 cycles.
- Address arithmetic is 7-bit modular. RAM_BASE + WORDS must not exceed 128 (checked by an elaboration assertion).
- No combinational path from seg_ready to ram_rd_en. seg_valid does not depend on seg_ready.

Decomposition:
- Shared package lcd_pkg holds:
  - scan_state_t enum (IDLE, REQ, WAIT, EMIT, EMIT_BS, DONE)
  - constants SEG_BS_BASE = 8'd128 and LCD_H_COUNT = 4
  - a seg_addr field layout helper function
- Single module; no sub-module is warranted. The pending-tick latch and latency counter are small enough to stay inline.

Test Plan:
- RAM[0x60] = 4'b1010, others 0, BP = 1, BC = 0, ready held high -> beats addr 0..3 carry seg_on 0,1,0,1; every other RAM beat is 0; frame_done after 132 beats.
- BC = 1 with RAM all 4'hF, L = Y = 4'hF -> all 132 beats have seg_on = 0. Changing BC mid-frame has no effect until the next frame.
- ram_busy held high for 5 cycles during REQ of word 3 -> ram_rd_en stays 0 for those 5 cycles; the read is issued on the first free cycle; data is correct.
- seg_ready toggled 1/0 randomly -> each beat is stable while stalled, no beats are lost or duplicated, order is addr 0..131.
- frame_tick pulsed three times during one scan -> exactly one extra scan follows with no IDLE cycle in between; two frame_done pulses in total.
- reset_n low at beat 40 -> next cycle all outputs are 0 and no frame_done; a fresh frame_tick produces a complete frame starting at addr 0.
